// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for the iterative binary-to-BCD converter.
//   - state_t        : converter control states
//   - BCD_W          : bits per BCD digit
//   - clog2()        : width needed to hold values 0..value-1
//   - digits_needed(): decimal digits needed for an unsigned bin_w-bit value
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int BCD_W = 4;

  // Number of bits needed to encode 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        bits++;
        rem = rem >> 1;
      end
    end
    return bits;
  endfunction

  // Decimal digits of 2^bin_w - 1, i.e. floor(bin_w * log10(2)) + 1.
  // bin_w * log10(2) is never an integer for bin_w > 0, so the fixed-point
  // approximation of log10(2) cannot land on the wrong side of a boundary
  // for any practical width.
  function automatic int digits_needed(input int bin_w);
    return (bin_w * 30103) / 100000 + 1;
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
//   One double-dabble correction stage: a digit of 5 or more gets 3 added so
//   that the following left shift carries correctly into the next decade.
//
//   Ports:
//     digit    in  BCD_W  scratch BCD digit before the shift
//     adjusted out BCD_W  digit after the add-3 correction
// -----------------------------------------------------------------------------
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adjusted
);

  localparam logic [BCD_W-1:0] ADJ_LIMIT = BCD_W'(5);
  localparam logic [BCD_W-1:0] ADJ_ADD   = BCD_W'(3);

  // A legal digit (0..9) maps into 0..4 or 8..12, so bit 3 of the result is
  // exactly the decimal carry produced by the shift that follows.
  assign adjusted = (digit >= ADJ_LIMIT) ? (digit + ADJ_ADD) : digit;

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Iterative (double-dabble) binary-to-BCD converter with start/done
//   handshake. One input bit is consumed per clock, so a conversion takes a
//   fixed BIN_W cycles after the accepting edge regardless of value.
//
//   Parameters:
//     BIN_W     binary input width (>= 2)
//     DIGITS    number of BCD output digits (>= 1)
//     SIGNED_EN 1 = honour signed_mode, 0 = always unsigned
//
//   Ports:
//     clk          in   1         system clock, rising edge
//     reset        in   1         synchronous, active-high reset
//     start        in   1         conversion request, sampled only when idle
//     signed_mode  in   1         bin_in is two's complement
//     bin_in       in   BIN_W     value to convert, sampled on accept
//     busy         out  1         conversion in progress
//     done         out  1         one-cycle pulse, results valid
//     bcd          out  4*DIGITS  packed BCD, digit 0 in [3:0]
//     neg          out  1         result is negative
//     ovf          out  1         magnitude needed more than DIGITS digits;
//                                 bcd then holds the value modulo 10^DIGITS
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W     = 16,
  parameter int DIGITS    = 5,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    signed_mode,
  input  logic [BIN_W-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd,
  output logic                    neg,
  output logic                    ovf
);

  localparam int BCD_TOT = BCD_W * DIGITS;
  localparam int CNT_W   = clog2(BIN_W + 1);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // When DIGITS covers the full unsigned range no carry can ever leave the
  // top digit, so the overflow flag is tied off and its accumulator folds away.
  localparam bit OVF_POSSIBLE = (DIGITS < digits_needed(BIN_W));

  // ---------------------------------------------------------------------------
  // Elaboration checks
  // ---------------------------------------------------------------------------
  if (BIN_W < 2) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W must be at least 2");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q;
  logic [BIN_W-1:0]   mag_q;       // magnitude being shifted out MSB first
  logic [BCD_TOT-1:0] scratch_q;   // BCD accumulator being built
  logic               ovf_acc_q;   // any carry lost off the top digit
  logic               neg_pend_q;  // sign captured at accept
  logic [CNT_W-1:0]   count_q;     // shifts remaining

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [BCD_TOT-1:0] scratch_adj;
  logic [BCD_TOT-1:0] scratch_shf;
  logic               carry_out;
  logic               take_neg;
  logic [BIN_W-1:0]   mag_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (scratch_q  [g*BCD_W +: BCD_W]),
      .adjusted (scratch_adj[g*BCD_W +: BCD_W])
    );
  end

  // Corrected scratch shifted left by one with the next magnitude bit entering
  // at the bottom; the bit falling off the top is the lost decimal carry.
  assign scratch_shf = {scratch_adj[BCD_TOT-2:0], mag_q[BIN_W-1]};
  assign carry_out   = scratch_adj[BCD_TOT-1];

  // Two's-complement negation in BIN_W bits: the most-negative input maps to
  // 2^(BIN_W-1), which is the correct unsigned magnitude.
  assign take_neg = SIGNED_EN && signed_mode && bin_in[BIN_W-1];
  assign mag_in   = take_neg ? -bin_in : bin_in;

  // ---------------------------------------------------------------------------
  // Control and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here is assigned with <= so all updates see the
  // values from before the edge; mixing in = would make the shift chain depend
  // on statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      mag_q      <= '0;
      scratch_q  <= '0;
      ovf_acc_q  <= 1'b0;
      neg_pend_q <= 1'b0;
      count_q    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bcd        <= '0;
      neg        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      done <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            mag_q      <= mag_in;
            neg_pend_q <= take_neg;
            scratch_q  <= '0;
            ovf_acc_q  <= 1'b0;
            count_q    <= CNT_INIT;
            busy       <= 1'b1;
            state_q    <= SHIFT;
          end
        end

        SHIFT: begin
          scratch_q <= scratch_shf;
          mag_q     <= {mag_q[BIN_W-2:0], 1'b0};
          ovf_acc_q <= ovf_acc_q | carry_out;
          count_q   <= count_q - CNT_ONE;

          // Last shift: publish the freshly shifted scratch, not scratch_q,
          // which still lags by one bit.
          if (count_q == CNT_ONE) begin
            bcd     <= scratch_shf;
            neg     <= neg_pend_q;
            ovf     <= OVF_POSSIBLE ? (ovf_acc_q | carry_out) : 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seq
//   Self-checking bench for bin2bcd_seq. Two instances: the default 16-bit /
//   5-digit converter and a 16-bit / 4-digit converter that can overflow.
//   Expected values come from a decimal arithmetic model of the conversion.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int LAT    = 16;
  localparam int BOUND  = 40;

  logic        clk = 1'b0;
  logic        reset;

  logic        start5, sm5;
  logic [15:0] bin5;
  logic        busy5, done5, neg5, ovf5;
  logic [19:0] bcd5;

  logic        start4, sm4;
  logic [15:0] bin4;
  logic        busy4, done4, neg4, ovf4;
  logic [15:0] bcd4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(5), .SIGNED_EN(1'b1)) u_dut5 (
    .clk         (clk),
    .reset       (reset),
    .start       (start5),
    .signed_mode (sm5),
    .bin_in      (bin5),
    .busy        (busy5),
    .done        (done5),
    .bcd         (bcd5),
    .neg         (neg5),
    .ovf         (ovf5)
  );

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(4), .SIGNED_EN(1'b1)) u_dut4 (
    .clk         (clk),
    .reset       (reset),
    .start       (start4),
    .signed_mode (sm4),
    .bin_in      (bin4),
    .busy        (busy4),
    .done        (done4),
    .bcd         (bcd4),
    .neg         (neg4),
    .ovf         (ovf4)
  );

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference: signed value -> magnitude -> base-10 digits.
  function automatic void model(input logic [15:0] b, input logic sm, input int nd,
                                output logic [19:0] e_bcd, output logic e_neg,
                                output logic e_ovf);
    longint v;
    longint m;
    longint lim;
    v = (sm && b[15]) ? longint'(b) - 65536 : longint'(b);
    m = (v < 0) ? -v : v;
    lim = 1;
    e_bcd = '0;
    for (int i = 0; i < nd; i++) begin
      e_bcd[4*i +: 4] = 4'((m / lim) % 10);
      lim = lim * 10;
    end
    e_ovf = (m >= lim);
    e_neg = (v < 0);
  endfunction

  // Start one conversion on the 5-digit instance and wait for done.
  // Entered and left at #1 after a rising edge; leaves in the done cycle.
  task automatic run5(input logic [15:0] b, input logic sm, output int lat);
    start5 = 1'b1; bin5 = b; sm5 = sm;
    step();
    start5 = 1'b0;
    lat = 0;
    while (!done5 && lat < BOUND) begin
      step();
      lat++;
    end
  endtask

  task automatic run4(input logic [15:0] b, input logic sm, output int lat);
    start4 = 1'b1; bin4 = b; sm4 = sm;
    step();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < BOUND) begin
      step();
      lat++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the 5-digit instance
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] bin;
    logic        sm;
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          pulses;
    logic [19:0] e_bcd;
    logic        e_neg, e_ovf;
    logic [15:0] rb;
    logic        rsm;

    vecs[0] = '{16'h270F, 1'b0, 20'h09999, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 1'b0, 20'h65535, 1'b0, 1'b0};
    vecs[2] = '{16'h0000, 1'b0, 20'h00000, 1'b0, 1'b0};
    vecs[3] = '{16'hFFF3, 1'b1, 20'h00013, 1'b1, 1'b0};
    vecs[4] = '{16'h8000, 1'b1, 20'h32768, 1'b1, 1'b0};
    vecs[5] = '{16'hFFF3, 1'b0, 20'h65523, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 1'b1, 20'h00000, 1'b0, 1'b0};
    vecs[7] = '{16'hFFFF, 1'b1, 20'h00001, 1'b1, 1'b0};

    reset  = 1'b1;
    start5 = 1'b0; sm5 = 1'b0; bin5 = '0;
    start4 = 1'b0; sm4 = 1'b0; bin4 = '0;
    step();
    step();

    check("reset_busy", 64'(busy5), 64'(0));
    check("reset_done", 64'(done5), 64'(0));
    check("reset_bcd",  64'(bcd5),  64'(0));
    check("reset_neg",  64'(neg5),  64'(0));
    check("reset_ovf",  64'(ovf5),  64'(0));
    check("reset_bcd4", 64'(bcd4),  64'(0));
    reset = 1'b0;
    step();

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      run5(vecs[i].bin, vecs[i].sm, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_bcd", i),     64'(bcd5), 64'(vecs[i].bcd));
      check($sformatf("vec%0d_neg", i),     64'(neg5), 64'(vecs[i].neg));
      check($sformatf("vec%0d_ovf", i),     64'(ovf5), 64'(vecs[i].ovf));
      step();
      check($sformatf("vec%0d_done_pulse", i), 64'(done5), 64'(0));
    end

    // 4-digit instance: overflow keeps the low digits
    run4(16'd12345, 1'b0, lat);
    check("d4_12345_latency", 64'(lat),  64'(LAT));
    check("d4_12345_bcd",     64'(bcd4), 64'(16'h2345));
    check("d4_12345_ovf",     64'(ovf4), 64'(1));
    step();
    run4(16'd9999, 1'b0, lat);
    check("d4_9999_bcd", 64'(bcd4), 64'(16'h9999));
    check("d4_9999_ovf", 64'(ovf4), 64'(0));
    step();
    run4(16'hFFFF, 1'b0, lat);
    check("d4_65535_bcd", 64'(bcd4), 64'(16'h5535));
    check("d4_65535_ovf", 64'(ovf4), 64'(1));
    step();

    // start while busy is ignored; start during done is accepted
    start5 = 1'b1; bin5 = 16'd5; sm5 = 1'b0;
    step();
    start5 = 1'b0;
    lat = 0;
    repeat (2) begin step(); lat++; end
    start5 = 1'b1; bin5 = 16'd8;
    step(); lat++;
    start5 = 1'b0;
    while (!done5 && lat < BOUND) begin step(); lat++; end
    check("busy_start_latency", 64'(lat),  64'(LAT));
    check("busy_start_bcd",     64'(bcd5), 64'(20'h00005));
    run5(16'd8, 1'b0, lat);
    check("b2b_latency", 64'(lat),  64'(LAT));
    check("b2b_bcd",     64'(bcd5), 64'(20'h00008));
    pulses = 0;
    repeat (20) begin step(); if (done5) pulses++; end
    check("b2b_no_extra_done", 64'(pulses), 64'(0));

    // Reset mid-conversion aborts without a done pulse
    start5 = 1'b1; bin5 = 16'd9999; sm5 = 1'b0;
    step();
    start5 = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 64'(busy5), 64'(0));
    check("abort_done", 64'(done5), 64'(0));
    check("abort_bcd",  64'(bcd5),  64'(0));
    pulses = 0;
    repeat (20) begin step(); if (done5) pulses++; end
    check("abort_no_done", 64'(pulses), 64'(0));
    run5(16'd13, 1'b0, lat);
    check("after_abort_latency", 64'(lat),  64'(LAT));
    check("after_abort_bcd",     64'(bcd5), 64'(20'h00013));
    step();

    // Randomised conversions against the decimal model
    for (int i = 0; i < 40; i++) begin
      rb  = 16'($urandom);
      rsm = 1'($urandom_range(0, 1));
      model(rb, rsm, 5, e_bcd, e_neg, e_ovf);
      run5(rb, rsm, lat);
      check($sformatf("rnd5_%0d_lat(%0h)", i, rb), 64'(lat),  64'(LAT));
      check($sformatf("rnd5_%0d_bcd(%0h)", i, rb), 64'(bcd5), 64'(e_bcd));
      check($sformatf("rnd5_%0d_neg(%0h)", i, rb), 64'(neg5), 64'(e_neg));
      check($sformatf("rnd5_%0d_ovf(%0h)", i, rb), 64'(ovf5), 64'(e_ovf));
      if (i % 3 == 0) step();
    end
    for (int i = 0; i < 20; i++) begin
      rb  = 16'($urandom);
      rsm = 1'($urandom_range(0, 1));
      model(rb, rsm, 4, e_bcd, e_neg, e_ovf);
      run4(rb, rsm, lat);
      check($sformatf("rnd4_%0d_bcd(%0h)", i, rb), 64'(bcd4), 64'(e_bcd[15:0]));
      check($sformatf("rnd4_%0d_neg(%0h)", i, rb), 64'(neg4), 64'(e_neg));
      check($sformatf("rnd4_%0d_ovf(%0h)", i, rb), 64'(ovf4), 64'(e_ovf));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_bin2bcd_seq
